// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) / key-schedule helpers for the
// iterative AES-128 decryptor.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} state_t;

  localparam logic [7:0] RCON [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] rcon(input logic [3:0] i);
    return (i < 4'd10) ? RCON[i] : 8'h00;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    logic [7:0] b;
    b = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ a;
  endfunction

  function automatic logic [7:0] mul11(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
  endfunction

  function automatic logic [7:0] mul13(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
  endfunction

  function automatic logic [7:0] mul14(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {mul14(a0) ^ mul11(a1) ^ mul13(a2) ^ mul9(a3),
            mul9(a0)  ^ mul14(a1) ^ mul11(a2) ^ mul13(a3),
            mul13(a0) ^ mul9(a1)  ^ mul14(a2) ^ mul11(a3),
            mul11(a0) ^ mul13(a1) ^ mul9(a2)  ^ mul14(a3)};
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] key_step_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Undo one forward step: k holds round key r+1, rc is the Rcon used to make it.
  function automatic logic [127:0] key_step_inv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_rot_word(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_128_dec_iter_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes,
// AddRoundKey, then InvMixColumns unless this is the final round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] i_state,
  input  logic [127:0] i_rkey,
  input  logic         i_last,
  output logic [127:0] o_state
);

  logic [127:0] w_sub;
  logic [127:0] w_ark;
  logic [127:0] w_mix;

  // Byte index 4*col+row; row r rotates right by r columns.
  always_comb begin
    w_sub = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        w_sub[8*(15-4*c-r) +: 8] = inv_sbox(i_state[8*(15-4*((c+4-r)%4)-r) +: 8]);
  end

  assign w_ark = w_sub ^ i_rkey;

  always_comb begin
    w_mix = '0;
    for (int c = 0; c < 4; c++)
      w_mix[32*(3-c) +: 32] = inv_mix_col(w_ark[32*(3-c) +: 32]);
  end

  assign o_state = i_last ? w_ark : w_mix;

endmodule

// File: rtl/aes_128_dec_iter.sv
// Iterative AES-128 decryptor: forward key expansion to round key 10, then
// ten inverse rounds with the key schedule run backwards on the fly.
module aes_128_dec_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_ct,
  input  logic [127:0] in_key,
  input  logic         in_key_same,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_pt,
  output logic         busy
);

  // state | meaning
  // IDLE  | waiting for a block, in_ready high
  // KEXP  | forward expansion, r_cnt counts steps 0..9
  // ROUND | inverse rounds, r_cnt counts rounds 9..0
  // DONE  | holding out_pt until out_ready

  state_t       r_state, w_state_nxt;
  logic [127:0] r_s, r_k, r_k10;
  logic         r_cache_vld;
  logic [3:0]   r_cnt;
  logic [127:0] r_out_pt;
  logic         r_out_valid;

  logic [127:0] w_k_fwd, w_k_inv, w_round;
  logic         w_hit;

  assign w_k_fwd = key_step_fwd(r_k, rcon(r_cnt));
  assign w_k_inv = key_step_inv(r_k, rcon(r_cnt));
  assign w_hit   = in_key_same && r_cache_vld;

  aes_inv_round u_round (
    .i_state (r_s),
    .i_rkey  (w_k_inv),
    .i_last  (r_cnt == 4'd0),
    .o_state (w_round)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = w_hit ? ROUND : KEXP;
      KEXP:    if (r_cnt == 4'd9) w_state_nxt = ROUND;
      ROUND:   if (r_cnt == 4'd0) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_s         <= '0;
      r_k         <= '0;
      r_k10       <= '0;
      r_cache_vld <= 1'b0;
      r_cnt       <= '0;
      r_out_pt    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            if (w_hit) begin
              r_s   <= in_ct ^ r_k10;
              r_k   <= r_k10;
              r_cnt <= 4'd9;
            end else begin
              r_s   <= in_ct;
              r_k   <= in_key;
              r_cnt <= 4'd0;
            end
          end
        end
        KEXP: begin
          r_k <= w_k_fwd;
          if (r_cnt == 4'd9) begin
            r_k10       <= w_k_fwd;
            r_cache_vld <= 1'b1;
            r_s         <= r_s ^ w_k_fwd;
            r_cnt       <= 4'd9;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ROUND: begin
          r_s <= w_round;
          r_k <= w_k_inv;
          if (r_cnt == 4'd0) begin
            r_out_pt    <= w_round;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign out_pt    = r_out_pt;

endmodule
